fpu_mul_pipe: RTL

- Parametrised, pipelined floating-point multiplier. Generalises the single-precision FPU operand/flag types to any EXP_W/MAN_W format.
- Accepts one multiply per cycle via valid/ready and returns a rounded result plus an 8-bit flags word. The flags word has the same bit order as flags_t: infinity, snan, qnan, inexact, overflow, underflow, zero, divbyzero, MSB first.
- Sits beside the existing FPU datapath as the MULT execution unit.

---
 rtl/fpu_mul_pipe_pkg.sv | 53 +++++
 rtl/fpu_mul_pipe_round.sv | 43 ++++
 rtl/fpu_mul_pipe.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_mul_pipe_pkg.sv
// Shared FPU types for the pipelined multiplier.
//   rmode_t    : rounding mode encoding used on the rmode port
//   flags_t    : 8-bit exception flags, MSB first:
//                infinity, snan, qnan, inexact, overflow, underflow, zero, divbyzero
//   fp_class_t : operand class produced by the input classifier
//   FP32_*     : single-precision field widths, used as parameter defaults
package fpu_mul_pipe_pkg;

  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rmode_t;

  typedef struct packed {
    logic infinity;
    logic snan;
    logic qnan;
    logic inexact;
    logic overflow;
    logic underflow;
    logic zero;
    logic divbyzero;
  } flags_t;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_NORMAL,
    FP_INF,
    FP_QNAN,
    FP_SNAN
  } fp_class_t;

  // Width-independent classifier: callers reduce the fields to four booleans.
  // A zero exponent flushes denormals to zero.
  function automatic fp_class_t fp_classify(input logic exp_zero, input logic exp_ones,
                                            input logic man_zero, input logic man_msb);
    fp_class_t c;
    c = FP_NORMAL;
    if (exp_zero) c = FP_ZERO;
    else if (exp_ones) begin
      if (man_zero)     c = FP_INF;
      else if (man_msb) c = FP_QNAN;
      else              c = FP_SNAN;
    end
    return c;
  endfunction

endpackage

// File: rtl/fpu_mul_pipe_round.sv
// fpu_round: combinational rounding of a normalised mantissa.
//   man       in  MAN_W  stored mantissa before rounding (hidden bit excluded)
//   guard     in  1      first bit below the mantissa LSB
//   sticky    in  1      OR of all bits below the guard bit
//   sign      in  1      sign of the result (directed modes depend on it)
//   rmode     in  2      rounding mode
//   man_rnd   out MAN_W  rounded mantissa
//   carry     out 1      increment rippled out of the mantissa (1.111.. -> 10.000..)
//   inexact   out 1      discarded bits were non-zero
module fpu_round
  import fpu_mul_pipe_pkg::*;
#(
  parameter int MAN_W = FP32_MAN_W
) (
  input  logic [MAN_W-1:0] man,
  input  logic             guard,
  input  logic             sticky,
  input  logic             sign,
  input  rmode_t           rmode,
  output logic [MAN_W-1:0] man_rnd,
  output logic             carry,
  output logic             inexact
);

  logic inc;

  always_comb begin
    inc = 1'b0;
    case (rmode)
      RM_RNE:  inc = guard & (sticky | man[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = ~sign & (guard | sticky);
      RM_RDN:  inc = sign & (guard | sticky);
      default: inc = 1'b0;
    endcase
  end

  // On carry the mantissa wraps to zero, which is exactly the right-shifted
  // value of 10.000..; the caller only has to bump the exponent.
  assign {carry, man_rnd} = {1'b0, man} + {{MAN_W{1'b0}}, inc};
  assign inexact = guard | sticky;

endmodule

// File: rtl/fpu_mul_pipe.sv
// fpu_mul_pipe: three-stage pipelined floating-point multiplier (MULT unit).
//   S1: classify, significand product, biased exponent sum, sign
//   S2: one-bit normalise, guard/sticky extraction
//   S3: round, overflow/underflow/special handling, pack (result/flags registered)
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready low only while the output stalls)
//   opa, opb            operands {sign, exp, man}, W = 1+EXP_W+MAN_W bits
//   rmode               rounding mode
//   out_valid/out_ready result handshake
//   result, flags       product and exception flags (flags_t order)
// Optional (macro FPU_MUL_STICKY_FLAGS_EN):
//   clear_flags         zeroes sticky_flags next cycle, wins over a coincident handshake
//   sticky_flags        OR of flags over every output handshake since reset/clear
module fpu_mul_pipe
  import fpu_mul_pipe_pkg::*;
#(
  parameter int EXP_W = FP32_EXP_W,
  parameter int MAN_W = FP32_MAN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] opa,
  input  logic [EXP_W+MAN_W:0] opb,
  input  rmode_t               rmode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output flags_t               flags
`ifdef FPU_MUL_STICKY_FLAGS_EN
  ,
  input  logic                 clear_flags,
  output logic [7:0]           sticky_flags
`endif
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int EW   = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;

  localparam logic signed [EW-1:0] BIAS_S    = EW'(BIAS);
  localparam logic signed [EW-1:0] EXP_ONES  = EW'(2 ** EXP_W - 1);
  localparam logic signed [EW-1:0] EXP_ONE   = EW'(1);
  localparam logic signed [EW-1:0] EXP_ZERO  = EW'(0);
  localparam logic [W-1:0]         CANON_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Handshake: the whole pipe moves together, so a bubble in S3 never stalls.
  logic stall, advance;
  assign stall    = out_valid & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = advance;

  // ---------------- S1: classify / multiply ----------------
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  fp_class_t        cls_a, cls_b;

  assign {sa, ea, ma} = opa;
  assign {sb, eb, mb} = opb;
  assign cls_a = fp_classify(ea == '0, &ea, ma == '0, ma[MAN_W-1]);
  assign cls_b = fp_classify(eb == '0, &eb, mb == '0, mb[MAN_W-1]);

  logic                   s1_valid;
  logic                   s1_sign;
  fp_class_t              s1_cls_a, s1_cls_b;
  logic signed [EW-1:0]   s1_exp;
  logic [PW-1:0]          s1_prod;
  rmode_t                 s1_rmode;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign  <= sa ^ sb;
        s1_cls_a <= cls_a;
        s1_cls_b <= cls_b;
        s1_exp   <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
        s1_prod  <= PW'({1'b1, ma}) * PW'({1'b1, mb});
        s1_rmode <= rmode;
      end
    end
  end

  // ---------------- S2: normalise ----------------
  // Product of two [1,2) significands lies in [1,4): at most one bit of shift.
  logic                 n_msb;
  logic [MAN_W-1:0]     n_man;
  logic                 n_guard, n_sticky;
  logic signed [EW-1:0] n_exp;

  always_comb begin
    n_msb    = s1_prod[PW-1];
    n_man    = s1_prod[PW-3 -: MAN_W];
    n_guard  = s1_prod[MAN_W-1];
    n_sticky = |s1_prod[MAN_W-2:0];
    n_exp    = s1_exp;
    if (n_msb) begin
      n_man    = s1_prod[PW-2 -: MAN_W];
      n_guard  = s1_prod[MAN_W];
      n_sticky = |s1_prod[MAN_W-1:0];
      n_exp    = s1_exp + EXP_ONE;
    end
  end

  logic                 s2_valid;
  logic                 s2_sign;
  fp_class_t            s2_cls_a, s2_cls_b;
  logic signed [EW-1:0] s2_exp;
  logic [MAN_W-1:0]     s2_man;
  logic                 s2_guard, s2_sticky;
  rmode_t               s2_rmode;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign   <= s1_sign;
        s2_cls_a  <= s1_cls_a;
        s2_cls_b  <= s1_cls_b;
        s2_exp    <= n_exp;
        s2_man    <= n_man;
        s2_guard  <= n_guard;
        s2_sticky <= n_sticky;
        s2_rmode  <= s1_rmode;
      end
    end
  end

  // ---------------- S3: round / pack ----------------
  logic [MAN_W-1:0]     r_man;
  logic                 r_carry, r_inexact;
  logic signed [EW-1:0] exp_f;

  fpu_round #(.MAN_W(MAN_W)) u_round (
    .man     (s2_man),
    .guard   (s2_guard),
    .sticky  (s2_sticky),
    .sign    (s2_sign),
    .rmode   (s2_rmode),
    .man_rnd (r_man),
    .carry   (r_carry),
    .inexact (r_inexact)
  );

  assign exp_f = s2_exp + (r_carry ? EXP_ONE : EXP_ZERO);

  logic     any_nan, any_snan, any_inf, any_zero, ovf_to_inf;
  logic [W-1:0] pk_result;
  flags_t   pk_flags;

  assign any_snan = (s2_cls_a == FP_SNAN) | (s2_cls_b == FP_SNAN);
  assign any_nan  = any_snan | (s2_cls_a == FP_QNAN) | (s2_cls_b == FP_QNAN);
  assign any_inf  = (s2_cls_a == FP_INF)  | (s2_cls_b == FP_INF);
  assign any_zero = (s2_cls_a == FP_ZERO) | (s2_cls_b == FP_ZERO);

  // Overflow saturates to infinity only when the rounding direction points away from zero.
  assign ovf_to_inf = (s2_rmode == RM_RNE) |
                      ((s2_rmode == RM_RUP) & ~s2_sign) |
                      ((s2_rmode == RM_RDN) &  s2_sign);

  always_comb begin
    pk_result = '0;
    pk_flags  = '0;
    if (any_nan) begin
      pk_result     = CANON_QNAN;
      pk_flags.qnan = 1'b1;
      pk_flags.snan = any_snan;
    end else if (any_inf & any_zero) begin
      pk_result     = CANON_QNAN;
      pk_flags.qnan = 1'b1;
    end else if (any_inf) begin
      pk_result         = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      pk_flags.infinity = 1'b1;
    end else if (any_zero) begin
      pk_result     = {s2_sign, {(W-1){1'b0}}};
      pk_flags.zero = 1'b1;
    end else if (exp_f >= EXP_ONES) begin
      pk_flags.overflow = 1'b1;
      pk_flags.inexact  = 1'b1;
      if (ovf_to_inf) begin
        pk_result         = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        pk_flags.infinity = 1'b1;
      end else begin
        pk_result = {s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      end
    end else if (exp_f[EW-1] | (exp_f == EXP_ZERO)) begin
      pk_result          = {s2_sign, {(W-1){1'b0}}};
      pk_flags.underflow = 1'b1;
      pk_flags.inexact   = 1'b1;
      pk_flags.zero      = 1'b1;
    end else begin
      pk_result        = {s2_sign, exp_f[EXP_W-1:0], r_man};
      pk_flags.inexact = r_inexact;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (advance) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        result <= pk_result;
        flags  <= pk_flags;
      end
    end
  end

`ifdef FPU_MUL_STICKY_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst)                         sticky_flags <= '0;
    else if (clear_flags)            sticky_flags <= '0;
    else if (out_valid & out_ready)  sticky_flags <= sticky_flags | flags;
  end
`endif

endmodule
